// File: rtl/pool_engine.sv
// pool_engine: streaming max/average pooling over windows of 2^win_log2 elements,
// CH signed lanes processed in parallel.
//
// Optional feature macro: POOL_ENGINE_AVG_EN
//   defined   -> mode selects average (0) or max (1) pooling
//   undefined -> no adders/shifters are built, mode is ignored, max pooling only
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   en         block enable; 0 clears the window, accumulators and output on the next edge
//   mode       0 = average, 1 = max (latched on the first element of a window)
//   win_log2   window size exponent (latched on the first element, clamped to LOG2_KMAX)
//   in_valid   input element valid
//   in_ready   input element may be accepted
//   in_data    CH lanes of DW-bit signed data, lane c at [c*DW +: DW]
//   out_valid  pooled result valid
//   out_ready  downstream accepts the result
//   out_data   pooled result per lane, same packing as in_data
//   busy       a window is partially accumulated
module pool_engine #(
    parameter int unsigned DW        = 16,
    parameter int unsigned CH        = 4,
    parameter int unsigned LOG2_KMAX = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic [2:0]         win_log2,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CH*DW-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CH*DW-1:0]   out_data,
    output logic               busy
);

    localparam int unsigned CW = LOG2_KMAX + 1;
`ifdef POOL_ENGINE_AVG_EN
    // Wide enough to sum 2^LOG2_KMAX elements without overflow.
    localparam int unsigned AW = DW + LOG2_KMAX;
`else
    localparam int unsigned AW = DW;
`endif
    localparam logic [2:0] WlMax = 3'(LOG2_KMAX);

    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           wl_q, wl_d;
    logic signed [AW-1:0] acc_q [CH];
    logic signed [AW-1:0] acc_d [CH];
    logic                 out_valid_q, out_valid_d;
    logic [CH*DW-1:0]     out_data_q, out_data_d;

    logic                 accept;
    logic                 first;
    logic                 last;
    logic [2:0]           wl_eff;
    logic [2:0]           cur_wl;
    logic signed [AW-1:0] nxt [CH];
    logic [CH*DW-1:0]     res_flat;

`ifdef POOL_ENGINE_AVG_EN
    logic mode_q, mode_d;
    logic cur_mode;
    assign cur_mode = first ? mode : mode_q;
`else
    logic unused_mode;
    assign unused_mode = mode;
`endif

    assign in_ready = en && !(out_valid_q && !out_ready);
    assign accept   = in_valid && in_ready;
    assign first    = (cnt_q == '0);
    assign wl_eff   = (32'(win_log2) > LOG2_KMAX) ? WlMax : win_log2;
    // The first element of a window uses the live config; later ones use the latched copy.
    assign cur_wl   = first ? wl_eff : wl_q;
    assign last     = (cnt_q == CW'((32'd1 << cur_wl) - 32'd1));

    for (genvar c = 0; c < CH; c++) begin : g_lane
        logic signed [DW-1:0] x;
        logic signed [DW-1:0] acc_lo;
        logic signed [DW-1:0] max_v;

        assign x      = in_data[c*DW +: DW];
        assign acc_lo = DW'(acc_q[c]);
        assign max_v  = (first || (x > acc_lo)) ? x : acc_lo;

`ifdef POOL_ENGINE_AVG_EN
        logic signed [AW-1:0] sum_v;
        logic signed [DW-1:0] avg_v;

        assign sum_v = first ? AW'(x) : (acc_q[c] + AW'(x));
        // Arithmetic shift rounds toward minus infinity.
        assign avg_v = DW'(sum_v >>> cur_wl);
        assign nxt[c] = cur_mode ? AW'(max_v) : sum_v;
        assign res_flat[c*DW +: DW] = cur_mode ? max_v : avg_v;
`else
        assign nxt[c] = max_v;
        assign res_flat[c*DW +: DW] = max_v;
`endif
    end

    always_comb begin
        cnt_d       = cnt_q;
        wl_d        = wl_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        for (int c = 0; c < CH; c++) begin
            acc_d[c] = acc_q[c];
        end
`ifdef POOL_ENGINE_AVG_EN
        mode_d = mode_q;
`endif

        if (!en) begin
            cnt_d       = '0;
            wl_d        = '0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            for (int c = 0; c < CH; c++) begin
                acc_d[c] = '0;
            end
`ifdef POOL_ENGINE_AVG_EN
            mode_d = 1'b0;
`endif
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
            if (accept) begin
                if (first) begin
                    wl_d = wl_eff;
`ifdef POOL_ENGINE_AVG_EN
                    mode_d = mode;
`endif
                end
                if (last) begin
                    // A new result overrides the handshake clear: no bubble.
                    cnt_d       = '0;
                    out_valid_d = 1'b1;
                    out_data_d  = res_flat;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    for (int c = 0; c < CH; c++) begin
                        acc_d[c] = nxt[c];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            wl_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int c = 0; c < CH; c++) begin
                acc_q[c] <= '0;
            end
`ifdef POOL_ENGINE_AVG_EN
            mode_q <= 1'b0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            wl_q        <= wl_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            for (int c = 0; c < CH; c++) begin
                acc_q[c] <= acc_d[c];
            end
`ifdef POOL_ENGINE_AVG_EN
            mode_q <= mode_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (cnt_q != '0);

endmodule

// File: tb/tb_pool_engine.sv
// Self-checking bench for pool_engine: table-driven window vectors, hand-written
// handshake/enable/reset sequences, and a randomized run checked against a
// window-list reference model. Honours POOL_ENGINE_AVG_EN the same way as the design.
`timescale 1ns/1ps
module tb_pool_engine;

    localparam int DW = 16;
    localparam int CH = 4;
    localparam int KM = 4;
`ifdef POOL_ENGINE_AVG_EN
    localparam bit AVG_EN = 1'b1;
`else
    localparam bit AVG_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             mode;
    logic [2:0]       win_log2;
    logic             in_valid;
    logic             in_ready;
    logic [CH*DW-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [CH*DW-1:0] out_data;
    logic             busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pool_engine #(.DW(DW), .CH(CH), .LOG2_KMAX(KM)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .win_log2  (win_log2),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    // Reference model: the current window is kept as a list of element values per lane.
    bit               m_ov;
    logic [CH*DW-1:0] m_od;
    int               m_n;
    bit               m_avg;
    int               m_k;
    int               m_win [CH][16];

    function automatic int lane(input logic [CH*DW-1:0] d, input int c);
        logic signed [DW-1:0] v;
        v = d[c*DW +: DW];
        return int'(v);
    endfunction

    function automatic logic [CH*DW-1:0] pack4(input int a, input int b, input int c,
                                               input int d);
        logic [CH*DW-1:0] r;
        r[0*DW +: DW] = DW'(a);
        r[1*DW +: DW] = DW'(b);
        r[2*DW +: DW] = DW'(c);
        r[3*DW +: DW] = DW'(d);
        return r;
    endfunction

    function automatic bit model_in_ready();
        return en && !(m_ov && !out_ready);
    endfunction

    task automatic model_reset();
        m_ov = 1'b0;
        m_od = '0;
        m_n  = 0;
    endtask

    task automatic model_edge(input bit acc);
        int n, r, sum, q;
        if (!en) begin
            model_reset();
            return;
        end
        if (m_ov && out_ready) m_ov = 1'b0;
        if (acc) begin
            if (m_n == 0) begin
                m_avg = AVG_EN ? (mode == 1'b0) : 1'b0;
                m_k   = (int'(win_log2) > KM) ? KM : int'(win_log2);
            end
            for (int c = 0; c < CH; c++) m_win[c][m_n] = lane(in_data, c);
            m_n++;
            n = 1 << m_k;
            if (m_n == n) begin
                for (int c = 0; c < CH; c++) begin
                    if (m_avg) begin
                        sum = 0;
                        for (int i = 0; i < n; i++) sum += m_win[c][i];
                        q = sum / n;
                        if ((sum % n != 0) && (sum < 0)) q -= 1;
                        r = q;
                    end else begin
                        r = m_win[c][0];
                        for (int i = 1; i < n; i++) if (m_win[c][i] > r) r = m_win[c][i];
                    end
                    m_od[c*DW +: DW] = DW'(r);
                end
                m_ov = 1'b1;
                m_n  = 0;
            end
        end
    endtask

    task automatic check(input string name, input logic [CH*DW-1:0] got,
                         input logic [CH*DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_ov"}, {63'd0, out_valid}, {63'd0, m_ov});
        check({tag, "_od"}, out_data, m_od);
        check({tag, "_busy"}, {63'd0, busy}, {63'd0, (m_n != 0)});
        check({tag, "_rdy"}, {63'd0, in_ready}, {63'd0, model_in_ready()});
    endtask

    // One clock: decide acceptance from pre-edge inputs, then sample 1 ns after the edge.
    task automatic tick();
        bit a;
        a = in_valid && model_in_ready();
        @(posedge clk);
        #1;
        model_edge(a);
    endtask

    task automatic feed(input logic [CH*DW-1:0] d);
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    typedef struct {
        logic               md;
        logic [2:0]         wl;
        int                 n;
        logic [4*CH*DW-1:0] el;
        logic [CH*DW-1:0]   exp;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [CH*DW-1:0] hold;

        vecs[0].md = 1'b1; vecs[0].wl = 3'd2; vecs[0].n = 4;
        vecs[0].el = {pack4(2, -4, 0, 150), pack4(9, -3, 0, -300),
                      pack4(-7, -2, 0, 200), pack4(3, -1, 0, 100)};
        vecs[0].exp = pack4(9, -1, 0, 200);
        vecs[1].md = 1'b0; vecs[1].wl = 3'd2; vecs[1].n = 4;
        vecs[1].el = {pack4(-2, 5, 0, 32767), pack4(-2, 4, 0, 32767),
                      pack4(-2, 4, 0, 32767), pack4(-1, 4, -5, 32767)};
        vecs[1].exp = AVG_EN ? pack4(-2, 4, -2, 32767) : pack4(-1, 5, 0, 32767);
        vecs[2].md = 1'b1; vecs[2].wl = 3'd1; vecs[2].n = 2;
        vecs[2].el = {128'd0, pack4(5, -3, -1, -32768), pack4(5, -8, 0, 32767)};
        vecs[2].exp = pack4(5, -3, 0, 32767);
        vecs[3].md = 1'b0; vecs[3].wl = 3'd0; vecs[3].n = 1;
        vecs[3].el = {192'd0, pack4(100, -5, 7, -32768)};
        vecs[3].exp = pack4(100, -5, 7, -32768);
        vecs[4].md = 1'b0; vecs[4].wl = 3'd1; vecs[4].n = 2;
        vecs[4].el = {128'd0, pack4(4, -4, 0, 0), pack4(3, -3, 1, -1)};
        vecs[4].exp = AVG_EN ? pack4(3, -4, 0, -1) : pack4(4, -3, 1, 0);

        rst_n = 1'b0; en = 1'b1; mode = 1'b0; win_log2 = 3'd0;
        in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
        model_reset();
        #2;
        check("rst_ov", {63'd0, out_valid}, 64'd0);
        check("rst_od", out_data, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_rdy", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven windows.
        for (int v = 0; v < 5; v++) begin
            mode      = vecs[v].md;
            win_log2  = vecs[v].wl;
            out_ready = 1'b1;
            for (int i = 0; i < vecs[v].n; i++) begin
                feed(vecs[v].el[i*CH*DW +: CH*DW]);
                if (i < vecs[v].n - 1) check($sformatf("tbl%0d_busy", v), {63'd0, busy}, 64'd1);
            end
            check($sformatf("tbl%0d_ov", v), {63'd0, out_valid}, 64'd1);
            check($sformatf("tbl%0d_od", v), out_data, vecs[v].exp);
            check_all($sformatf("tbl%0d_mdl", v));
            tick();
            check($sformatf("tbl%0d_drain", v), {63'd0, out_valid}, 64'd0);
        end

        // Backpressure: result pending blocks input, no element is lost.
        mode = 1'b1; win_log2 = 3'd1; out_ready = 1'b0;
        feed(pack4(10, 20, 30, 40));
        feed(pack4(11, 19, 31, 39));
        check("bp_ov", {63'd0, out_valid}, 64'd1);
        check("bp_od", out_data, pack4(11, 20, 31, 40));
        in_data = pack4(1, 2, 3, 4);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_rdy_low", {63'd0, in_ready}, 64'd0);
            check("bp_hold", out_data, pack4(11, 20, 31, 40));
            check("bp_hold_ov", {63'd0, out_valid}, 64'd1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_rdy_high", {63'd0, in_ready}, 64'd1);
        tick();
        check("bp_hs_ov", {63'd0, out_valid}, 64'd0);
        check("bp_hs_busy", {63'd0, busy}, 64'd1);
        feed(pack4(0, 5, -3, 4));
        check("bp_next", out_data, pack4(1, 5, 3, 4));
        check("bp_next_ov", {63'd0, out_valid}, 64'd1);
        tick();

        // Config changes mid-window only take effect on the next window.
        mode = 1'b1; win_log2 = 3'd1;
        feed(pack4(-4, 8, 2, 2));
        mode = 1'b0; win_log2 = 3'd2;
        feed(pack4(6, -8, 3, 1));
        check("cfg_ov", {63'd0, out_valid}, 64'd1);
        check("cfg_od", out_data, pack4(6, 8, 3, 2));
        tick();

        // Back-to-back single-element windows: no bubble while handshaking.
        win_log2 = 3'd0; mode = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = pack4(i * 7 - 9, -i, 1000 + i, -2000 * i);
            hold = in_data;
            tick();
            check("b2b_ov", {63'd0, out_valid}, 64'd1);
            check("b2b_od", out_data, hold);
        end
        in_valid = 1'b0;
        tick();

        // Enable drop discards a partial window.
        mode = 1'b0; win_log2 = 3'd2;
        feed(pack4(7, 7, 7, 7));
        feed(pack4(7, 7, 7, 7));
        check("en_busy", {63'd0, busy}, 64'd1);
        en = 1'b0;
        tick();
        check("en_busy0", {63'd0, busy}, 64'd0);
        check("en_ov0", {63'd0, out_valid}, 64'd0);
        check("en_od0", out_data, 64'd0);
        check("en_rdy0", {63'd0, in_ready}, 64'd0);
        en = 1'b1;
        for (int i = 0; i < 4; i++) feed(pack4(1, 1, 1, 1));
        check("en_res_ov", {63'd0, out_valid}, 64'd1);
        check("en_res", out_data, pack4(1, 1, 1, 1));
        tick();

        // Async reset with a result pending.
        mode = 1'b1; win_log2 = 3'd1; out_ready = 1'b0;
        feed(pack4(3, 3, 3, 3));
        feed(pack4(4, 4, 4, 4));
        check("ar1_pre", {63'd0, out_valid}, 64'd1);
        #2; rst_n = 1'b0; #1;
        check("ar1_ov", {63'd0, out_valid}, 64'd0);
        check("ar1_od", out_data, 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Async reset mid-window, then a full window.
        win_log2 = 3'd2;
        feed(pack4(90, 90, 90, 90));
        feed(pack4(80, 80, 80, 80));
        check("ar2_pre", {63'd0, busy}, 64'd1);
        #2; rst_n = 1'b0; #1;
        check("ar2_busy", {63'd0, busy}, 64'd0);
        check("ar2_ov", {63'd0, out_valid}, 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        feed(pack4(1, -1, 5, -5));
        feed(pack4(2, -2, 6, -6));
        feed(pack4(3, -3, 7, -7));
        feed(pack4(0, -4, 8, -8));
        check("ar2_res_ov", {63'd0, out_valid}, 64'd1);
        check("ar2_res", out_data, pack4(3, -1, 8, -5));
        tick();

        // Randomized run against the reference model.
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 63) != 0);
            if ($urandom_range(0, 7) == 0) mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) win_log2 = 3'($urandom_range(0, 7));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = {$urandom(), $urandom()};
            tick();
            check_all("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pool_engine.md
POOL_ENGINE -- requirements
Module: pool_engine

Interface
REQ-001 SHALL have parameter DW, default 16, meaning signed lane data width in bits.
REQ-002 SHALL have parameter CH, default 4, meaning number of parallel channels (lanes).
REQ-003 SHALL have parameter LOG2_KMAX, default 4, meaning maximum window size exponent (max 16 elements).
REQ-004 SHALL have port clk, input, 1, meaning clock; all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning reset, asynchronous, active-low.
REQ-006 SHALL have port en, input, 1, meaning block enable; 0 = synchronous clear.
REQ-007 SHALL have port mode, input, 1, meaning 0 = average pooling, 1 = max pooling.
REQ-008 SHALL have port win_log2, input, 3, meaning window size = 2^win_log2 elements, legal range 0..LOG2_KMAX.
REQ-009 SHALL have ports in_valid, input, 1, and in_ready, output, 1, meaning input handshake.
REQ-010 SHALL have port in_data, input, CH*DW, meaning CH signed lanes, lane c at bits [c*DW +: DW].
REQ-011 SHALL have ports out_valid, output, 1, and out_ready, input, 1, meaning output handshake.
REQ-012 SHALL have port out_data, output, CH*DW, meaning pooled result per lane, same packing as in_data.
REQ-013 SHALL have port busy, output, 1, meaning a window is partially accumulated.

Function
REQ-014 SHALL accept an element when in_valid && in_ready at a rising edge.
REQ-015 SHALL drive in_ready = en && !(out_valid && !out_ready), combinationally.
REQ-016 SHALL latch mode and win_log2 when accepting the first element of a window; changes mid-window SHALL have no effect until the next window.
REQ-017 SHALL keep element counter cnt (LOG2_KMAX+1 bits): 0 at window start, incremented per accepted element, returned to 0 after the 2^win_log2-th element.
REQ-018 Max mode: per lane, first element loads the accumulator; each later element replaces it if strictly greater (signed compare).
REQ-019 Avg mode: per lane, sum in a DW+LOG2_KMAX-bit signed accumulator (no overflow possible); result = sum arithmetically shifted right by latched win_log2, truncated to DW bits (rounds toward minus infinity).
REQ-020 SHALL register the result into out_data and assert out_valid on the cycle after the last element of a window is accepted (latency 1).
REQ-021 SHALL hold out_data and out_valid stable until out_valid && out_ready; then out_valid SHALL deassert unless a new result is loaded on the same edge.
REQ-022 win_log2 = 0 SHALL pass every accepted element through unchanged with latency 1 in either mode.
REQ-023 Simultaneous output handshake and last-element acceptance SHALL load the new result and keep out_valid high without a bubble.
REQ-024 busy SHALL equal (cnt != 0).
REQ-025 en = 0 SHALL, on the next edge, clear cnt, accumulators, out_valid and out_data; a partial window SHALL be discarded.
REQ-026 win_log2 > LOG2_KMAX SHALL be treated as LOG2_KMAX.

Reset
REQ-027 rst_n low SHALL asynchronously clear cnt, accumulators, latched config, out_data (0) and out_valid (0); in_ready SHALL follow REQ-015 and busy SHALL be 0.
REQ-028 Reset mid-window SHALL discard the partial window; the first accepted element after release starts a new window.

Configuration
REQ-029 Macro POOL_ENGINE_AVG_EN defined: average mode SHALL be implemented per REQ-019.
REQ-030 Macro POOL_ENGINE_AVG_EN undefined: adders and shifters SHALL be omitted, mode SHALL be ignored, and max pooling SHALL always be performed.

Verification
REQ-031 CH=1, max, win_log2=2, inputs 3,-7,9,2 -> one cycle after 4th accept out_valid=1, out_data=9.
REQ-032 CH=1, avg, win_log2=2, inputs -1,-2,-2,-2 -> out_data=-2 (sum -7 >>> 2).
REQ-033 CH=4, max, win_log2=1, lane0 {5,5}, lane1 {-8,-3}, lane2 {0,-1}, lane3 {32767,-32768} -> out_data lanes {5,-3,0,32767}.
REQ-034 out_ready=0 while a result is pending, in_valid=1 continuously -> in_ready=0, out_data stable; out_ready=1 -> handshake, then accept resumes next edge with no lost element.
REQ-035 en dropped after 2 of 4 elements, re-raised, inputs 1,1,1,1 (avg) -> out_data=1; no stale contribution.
REQ-036 rst_n pulsed low mid-window, async, no clock edge -> out_valid=0, busy=0 immediately; next full window produces the correct result.
